// File: rtl/puf_key_loader_pkg.sv
// ----------------------------------------------------------------------------
// puf_key_loader_pkg
// Shared definitions for the PUF key loader: controller state encoding,
// challenge LFSR tap mask, default geometry and the substitute used when the
// requested challenge seed is all-zero (an all-zero LFSR would never move).
// ----------------------------------------------------------------------------
package puf_key_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_CHAL_W     = 64;
  localparam int DEF_SETTLE_CYC = 4;

  // x^64 + x^63 + x^61 + x^60 + 1 : feedback from bits 63, 62, 60, 59
  localparam logic [63:0] LFSR_TAPS     = 64'hD800_0000_0000_0000;
  localparam logic [63:0] ZERO_SEED_SUB = 64'h0000_0000_0000_0001;

endpackage

// File: rtl/challenge_lfsr.sv
// ----------------------------------------------------------------------------
// challenge_lfsr
// Fibonacci shift-left LFSR producing the arbiter-PUF challenge. The state
// register is the challenge itself, so o_state is a registered output.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (state -> 0)
//   i_load      : load i_seed (takes priority over i_step)
//   i_step      : advance one position
//   i_seed      : value loaded on i_load
//   o_state     : current LFSR state
// ----------------------------------------------------------------------------
module challenge_lfsr
  import puf_key_loader_pkg::*;
#(
  parameter int CHAL_W = DEF_CHAL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [CHAL_W-1:0] i_seed,
  output logic [CHAL_W-1:0] o_state
);

  logic [CHAL_W-1:0] r_state;
  logic              w_fb;

  assign w_fb    = ^(r_state & LFSR_TAPS[CHAL_W-1:0]);
  assign o_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= '0;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_step) begin
      r_state <= {r_state[CHAL_W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/puf_key_loader.sv
// ----------------------------------------------------------------------------
// puf_key_loader
// Collects a KEY_W-bit key from an arbiter PUF, one bit per challenge, and
// hands it to an AES core. Each challenge is held SETTLE_CYC cycles before
// the response is sampled; the first sampled bit lands in key_out[KEY_W-1].
// The AES core is kept in reset until a complete key is available.
//
// Build option: define PUF_MAJORITY_VOTE_EN to sample each challenge on three
// consecutive cycles and store the majority bit (SAMPLE phase lasts 3 cycles).
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start          : level-sampled key request, honoured in IDLE/DONE only
//   seed           : challenge LFSR seed captured with an accepted start
//   puf_challenge  : registered challenge to the PUF
//   puf_resp       : PUF response bit (synchronous to clk)
//   key_out        : assembled key
//   key_valid      : key_out holds a complete key
//   busy           : collection in progress
//   aes_reset      : AES core reset, released together with key_valid
// ----------------------------------------------------------------------------
module puf_key_loader
  import puf_key_loader_pkg::*;
#(
  parameter int KEY_W      = 128,
  parameter int CHAL_W     = DEF_CHAL_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed,
  output logic [CHAL_W-1:0] puf_challenge,
  input  logic              puf_resp,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic              busy,
  output logic              aes_reset
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t            r_state;
  logic [6:0]        r_bit_cnt;
  logic [3:0]        r_settle_cnt;
  logic [KEY_W-1:0]  r_key;
  logic              r_key_valid;
  logic              r_busy;
  logic              r_aes_reset;

  logic              w_accept;
  logic              w_last_sample;
  logic              w_bit;
  logic [CHAL_W-1:0] w_seed_eff;

  assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_seed_eff = (seed == '0) ? ZERO_SEED_SUB[CHAL_W-1:0] : seed;

`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0] r_vote_cnt;
  logic [1:0] r_votes;

  // Two earlier samples are registered; the third is taken live.
  assign w_last_sample = (r_state == ST_SAMPLE) && (r_vote_cnt == 2'd2);
  assign w_bit = (r_votes[0] & r_votes[1]) | (r_votes[0] & puf_resp) |
                 (r_votes[1] & puf_resp);
`else
  assign w_last_sample = (r_state == ST_SAMPLE);
  assign w_bit         = puf_resp;
`endif

  challenge_lfsr #(.CHAL_W(CHAL_W)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept),
    .i_step  (w_last_sample),
    .i_seed  (w_seed_eff),
    .o_state (puf_challenge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_settle_cnt <= '0;
      r_key        <= '0;
      r_key_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_aes_reset  <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
      r_vote_cnt   <= '0;
      r_votes      <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_APPLY;
            r_bit_cnt    <= '0;
            r_settle_cnt <= '0;
            r_key_valid  <= 1'b0;
            r_busy       <= 1'b1;
            r_aes_reset  <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
            r_vote_cnt   <= '0;
`endif
          end
        end
        ST_APPLY: begin
          r_settle_cnt <= r_settle_cnt + 4'd1;
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
`ifdef PUF_MAJORITY_VOTE_EN
          if (!w_last_sample) begin
            r_votes    <= {r_votes[0], puf_resp};
            r_vote_cnt <= r_vote_cnt + 2'd1;
          end else begin
            r_vote_cnt <= '0;
          end
`endif
          if (w_last_sample) begin
            r_key        <= {r_key[KEY_W-2:0], w_bit};
            r_settle_cnt <= '0;
            // Counter stops at 127 so it never wraps within a key.
            if (r_bit_cnt == 7'd127) begin
              r_state     <= ST_DONE;
              r_key_valid <= 1'b1;
              r_busy      <= 1'b0;
              r_aes_reset <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 7'd1;
              r_state   <= ST_APPLY;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign key_out   = r_key;
  assign key_valid = r_key_valid;
  assign busy      = r_busy;
  assign aes_reset = r_aes_reset;

endmodule

// File: tb/tb_puf_key_loader.sv
// ----------------------------------------------------------------------------
// tb_puf_key_loader
// Self-checking bench for puf_key_loader. A transaction-level model tracks
// cycles since the accepting edge and derives every output from that count;
// a compare process checks all outputs one time unit after every rising edge.
// ----------------------------------------------------------------------------
module tb_puf_key_loader;

  localparam int SETTLE = 4;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int V = 3;
`else
  localparam int V = 1;
`endif
  localparam int P = SETTLE + V;   // cycles per key bit
  localparam int L = 128 * P;      // accept-to-valid latency

  logic         clk;
  logic         reset;
  logic         start;
  logic [63:0]  seed;
  logic [63:0]  puf_challenge;
  logic         puf_resp;
  logic [127:0] key_out;
  logic         key_valid;
  logic         busy;
  logic         aes_reset;

  puf_key_loader #(.KEY_W(128), .CHAL_W(64), .SETTLE_CYC(SETTLE)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .seed          (seed),
    .puf_challenge (puf_challenge),
    .puf_resp      (puf_resp),
    .key_out       (key_out),
    .key_valid     (key_valid),
    .busy          (busy),
    .aes_reset     (aes_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lfsr_next(input logic [63:0] c);
    return {c[62:0], c[63] ^ c[62] ^ c[60] ^ c[59]};
  endfunction

  // ---------------- model state ----------------
  int           m_phase;   // 0 never started / reset, 1 collecting, 2 key complete
  int           m_k;       // cycles since accepting edge
  int           m_n;       // bits collected
  logic [63:0]  m_chal;
  logic [127:0] m_key;
  int           mode;      // 0 const 1, 1 resp = challenge bit0, 2 vote pattern
  logic [2:0]   pat;       // vote samples, pat[i] is the i-th sample of a bit
  int           cyc;
  int           acc_cyc;
  int           rise_cyc;
  logic         prev_valid;

  function automatic logic model_resp();
    if (mode == 0) return 1'b1;
    if (mode == 1) return m_chal[0];
    return ($countones(pat) >= 2);
  endfunction

  // ---------------- compare process ----------------
  initial begin
    m_phase = 0; m_k = 0; m_n = 0; m_chal = '0; m_key = '0;
    cyc = 0; acc_cyc = 0; rise_cyc = 0; prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        m_phase = 0; m_k = 0; m_n = 0; m_chal = '0; m_key = '0;
      end else if (start && m_phase != 1) begin
        m_phase = 1; m_k = 0; m_n = 0;
        m_chal  = (seed == 64'h0) ? 64'h1 : seed;
        acc_cyc = cyc;
      end else if (m_phase == 1) begin
        m_k++;
        if (m_k % P == 0) begin
          m_key  = {m_key[126:0], model_resp()};
          m_chal = lfsr_next(m_chal);
          m_n++;
          if (m_n == 128) m_phase = 2;
        end
      end
      if (key_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = key_valid;
      chk("key_out",       key_out,       m_key);
      chk("puf_challenge", puf_challenge, {64'h0, m_chal});
      chk("key_valid",     key_valid,     (m_phase == 2));
      chk("busy",          busy,          (m_phase == 1));
      chk("aes_reset",     aes_reset,     (m_phase != 2));
    end
  end

  // ---------------- PUF response driver ----------------
  initial begin
    int off;
    puf_resp = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0: puf_resp = 1'b1;
        1: puf_resp = puf_challenge[0];
        default: begin
          off = (m_k % P) - SETTLE;
          puf_resp = (m_phase == 1 && off >= 0 && off < 3) ? pat[off] : 1'b0;
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input logic [63:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit got = 1'b0;
    for (int i = 0; i < L + 100; i++) begin
      @(negedge clk);
      if (key_valid) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout: got key_valid=0 expected 1 within %0d cycles", name, L + 100);
    end
    chk({name, "_latency"}, 128'(rise_cyc - acc_cyc), 128'(L));
  endtask

  task automatic wait_bits(input int n);
    bit got = 1'b0;
    for (int i = 0; i < L + 100; i++) begin
      @(negedge clk);
      if (m_n == n && m_phase == 1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL wait_bits: got m_n=%0d expected %0d", m_n, n);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [127:0] k_ref;
    reset = 1'b1; start = 1'b0; seed = '0; mode = 0; pat = 3'b000;
    repeat (2) @(negedge clk);
    chk("rst_key",       key_out,       128'h0);
    chk("rst_challenge", puf_challenge, 128'h0);
    chk("rst_valid",     key_valid,     128'h0);
    chk("rst_busy",      busy,          128'h0);
    chk("rst_aes_reset", aes_reset,     128'h1);
    reset = 1'b0;

    // Model pins: hand-computed LFSR steps
    chk("lfsr_1",    lfsr_next(64'h1),                     128'h2);
    chk("lfsr_msb",  lfsr_next(64'h8000_0000_0000_0000),   128'h1);
    chk("lfsr_taps", lfsr_next(64'hD800_0000_0000_0001),   128'hB000_0000_0000_0002);

`ifndef PUF_MAJORITY_VOTE_EN
    // All-ones key, seed 1
    mode = 0;
    pulse_start(64'h1);
    chk("busy_after_start", busy, 128'h1);
    wait_valid("ones");
    chk("ones_latency_640", 128'(rise_cyc - acc_cyc), 128'd640);
    chk("ones_key", key_out, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    chk("ones_aes_reset", aes_reset, 128'h0);
    chk("ones_busy", busy, 128'h0);

    // seed 0 substitutes 1; response = challenge bit0
    mode = 1;
    pulse_start(64'h0);
    chk("seed0_challenge", puf_challenge, 128'h1);
    wait_valid("chalbit");
    // challenges 1,2,4..2^59 give bit0 = 1 then 59 zeros
    chk("chalbit_top_byte", {120'h0, key_out[127:120]}, 128'h80);
    k_ref = m_key;

    // Re-pulse start at bit 40: ignored
    pulse_start(64'h0);
    wait_bits(40);
    pulse_start(64'h1234_5678_9ABC_DEF0);
    wait_valid("restart");
    chk("restart_key", key_out, k_ref);

    // Reset at bit 50 aborts
    pulse_start(64'hDEAD_BEEF_0123_4567);
    wait_bits(50);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("abort_key",       key_out,   128'h0);
    chk("abort_busy",      busy,      128'h0);
    chk("abort_aes_reset", aes_reset, 128'h1);
    chk("abort_valid",     key_valid, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", busy, 128'h0);
    pulse_start(64'hDEAD_BEEF_0123_4567);
    wait_valid("fresh");
    chk("fresh_latency_640", 128'(rise_cyc - acc_cyc), 128'd640);
`else
    // Samples 1,0,1 -> majority 1
    mode = 2;
    pat  = 3'b101;
    pulse_start(64'h1);
    wait_valid("vote101");
    chk("vote101_latency_896", 128'(rise_cyc - acc_cyc), 128'd896);
    chk("vote101_key", key_out, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    // Samples 0,0,1 -> majority 0
    pat = 3'b100;
    pulse_start(64'h0);
    chk("vote_seed0_challenge", puf_challenge, 128'h1);
    wait_valid("vote001");
    chk("vote001_key", key_out, 128'h0);
    chk("vote001_aes_reset", aes_reset, 128'h0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/puf_key_loader.md
PUF_KEY_LOADER -- requirements
Module: puf_key_loader

Interface
REQ-001 Parameter: KEY_W, 128, key width; the only legal value is 128.
REQ-002 Parameter: CHAL_W, 64, arbiter-PUF challenge width.
REQ-003 Parameter: SETTLE_CYC, 4, cycles a challenge is held before sampling; legal range 1..15.
REQ-004 Port: clk, input, 1, clock; rising edge active.
REQ-005 Port: reset, input, 1, reset; asynchronous, active-high.
REQ-006 Port: start, input, 1, level-sampled request to generate a key.
REQ-007 Port: seed, input, CHAL_W, challenge LFSR seed, sampled when start is accepted.
REQ-008 Port: puf_challenge, output, CHAL_W, registered challenge driven to the PUF.
REQ-009 Port: puf_resp, input, 1, PUF response bit, synchronous to clk.
REQ-010 Port: key_out, output, KEY_W, assembled key for the AES core key input.
REQ-011 Port: key_valid, output, 1, high while key_out holds a complete key.
REQ-012 Port: busy, output, 1, high while collection is in progress.
REQ-013 Port: aes_reset, output, 1, drives the AES core reset; high until key_valid.

Function
REQ-014 FSM states: IDLE, APPLY, SAMPLE, DONE; all outputs registered.
REQ-015 Accept start in IDLE or DONE: load LFSR and puf_challenge with seed (seed==0 loads 64'h1), clear bit and settle counters, clear key_valid, set busy and aes_reset, go to APPLY.
REQ-016 start in APPLY or SAMPLE: ignored; no side effects.
REQ-017 APPLY: hold puf_challenge; settle counter increments each cycle; after SETTLE_CYC cycles go to SAMPLE.
REQ-018 SAMPLE (1 cycle): key_out <= {key_out[126:0], puf_resp}; step LFSR and update puf_challenge; increment bit counter.
REQ-019 After SAMPLE: if the bit counter was 127, go to DONE; otherwise go to APPLY with the settle counter cleared.
REQ-020 The first sampled bit ends in key_out[127] (MSB-first ordering).
REQ-021 LFSR is Fibonacci, shift-left; bit0 <= c[63]^c[62]^c[60]^c[59] (x^64+x^63+x^61+x^60+1).
REQ-022 key_out shall not change in APPLY; it changes only on a SAMPLE cycle or on reset.
REQ-023 Latency: key_valid rises 128*(SETTLE_CYC+1) cycles after the accepting edge (640 for the default).
REQ-024 DONE: key_valid=1, busy=0, aes_reset=0; key_out and puf_challenge hold until the next start or reset.
REQ-025 The bit counter is 7 bits and shall not wrap past 127 within one key.

Reset
REQ-026 Reset forces: state IDLE, key_out 0, puf_challenge 0, key_valid 0, busy 0, aes_reset 1, all counters 0.
REQ-027 Reset mid-collection aborts immediately; a partial key is never flagged valid; a new start is required.

Configuration
REQ-028 Macro PUF_MAJORITY_VOTE_EN defined: SAMPLE lasts 3 cycles, puf_resp is sampled once per cycle, the stored bit is the majority of the 3 samples, and the LFSR steps once on the third cycle.
REQ-029 With PUF_MAJORITY_VOTE_EN, latency is 128*(SETTLE_CYC+3) cycles (896 for the default).
REQ-030 Macro not defined: single-sample behaviour per REQ-018 and REQ-023; no vote logic is synthesized.

Structure
REQ-031 Shared package: state encoding enum, LFSR tap constant, default SETTLE_CYC and CHAL_W, and the 64'h1 zero-seed substitute.
REQ-032 Sub-module challenge_lfsr: load, step, seed in, state out; no other sub-modules.

Verification
REQ-033 seed=64'h1, puf_resp=1 constantly, pulse start -> key_valid after 640 cycles; key_out=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; aes_reset falls in the same cycle.
REQ-034 seed=0 -> puf_challenge=64'h1 after start; each SAMPLE matches the reference LFSR model; 128 steps total.
REQ-035 puf_resp = challenge bit0 at each SAMPLE -> key_out equals the model-predicted 128-bit sequence, MSB first.
REQ-036 start re-pulsed at bit 40 -> ignored; key_valid still at cycle 640; key_out unchanged versus the uninterrupted run.
REQ-037 reset asserted at bit 50 -> next edge shows key_out=0, busy=0, aes_reset=1; a fresh start completes normally.
REQ-038 PUF_MAJORITY_VOTE_EN defined, samples 1,0,1 per bit -> all-ones key after 896 cycles; samples 0,0,1 -> all-zeros key.
